// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrlState_t;

  localparam logic [2:0] MEMREAD_NONE = 3'b000;
  localparam logic [4:0] REG_ZERO     = 5'd0;

  // An operand only conflicts with a pending load when it is actually read.
  function automatic logic regMatch(input logic uses, input logic [4:0] src,
                                    input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_muldiv_busy_counter.sv
// rtl/pipeline_ctrl_muldiv_busy_counter.sv - iterative mul/div busy countdown with done pulse
module muldiv_busy_counter #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [5:0] LOAD_VALUE = 6'(MULDIV_CYCLES);

  logic [5:0] count;

  // done is registered so it lands in the cycle after the count reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 6'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        count <= LOAD_VALUE;
      end else if (count != 6'd0) begin
        count <= count - 6'd1;
        done  <= (count == 6'd1);
      end
    end
  end

  assign busy = (count != 6'd0);

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - merges load-use, mul/div, memory-wait and branch hazards into stage controls
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RegSource_ID,
  input  logic [4:0]  RegTarget_ID,
  input  logic        UsesRs_ID,
  input  logic        UsesRt_ID,
  input  logic        HiLoAccess_ID,
  input  logic        BranchTaken_ID,
  input  logic [4:0]  WriteRegAddr_EX,
  input  logic [2:0]  MemRead_EX,
  input  logic        MulDivStart_EX,
  input  logic        MemAccess_MEM,
  input  logic        DMemReady,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Write,
  output logic        MEMWB_Flush,
  output logic        MulDivBusy,
  output logic        MulDivDone,
  output logic        MemTimeout,
  output logic [31:0] StallCycles
);

  localparam logic [9:0] TIMEOUT_LIMIT = 10'(MEM_TIMEOUT);

  ctrlState_t state, nextState;
  logic [9:0] waitCnt;
  logic [9:0] waitInc;
  logic       freeze, mdHaz, luHaz;

  assign freeze = MemAccess_MEM & ~DMemReady;
  assign mdHaz  = HiLoAccess_ID & MulDivBusy;
  assign luHaz  = (MemRead_EX != MEMREAD_NONE) && (WriteRegAddr_EX != REG_ZERO) &&
                  (regMatch(UsesRs_ID, RegSource_ID, WriteRegAddr_EX) ||
                   regMatch(UsesRt_ID, RegTarget_ID, WriteRegAddr_EX));

  // Branch redirect is only honoured when no stall holds ID, since its operands may be stale.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Write = 1'b1;
    MEMWB_Flush = 1'b0;
    if (freeze) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Flush = 1'b1;
    end else if (mdHaz || luHaz) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (BranchTaken_ID) begin
      IFID_Flush = 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_RUN:      if (freeze) nextState = ST_MEM_WAIT;
      ST_MEM_WAIT: if (DMemReady || !MemAccess_MEM) nextState = ST_RUN;
      default:     nextState = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= nextState;
  end

  assign waitInc = (waitCnt == 10'h3FF) ? waitCnt : waitCnt + 10'd1;

  // waitCnt counts frozen edges, so it equals the number of wait cycles seen so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt    <= 10'd0;
      MemTimeout <= 1'b0;
    end else if (nextState == ST_RUN) begin
      waitCnt <= 10'd0;
    end else begin
      waitCnt <= waitInc;
      if (waitInc >= TIMEOUT_LIMIT) MemTimeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  StallCycles <= 32'd0;
    else if (!PCWrite && StallCycles != '1)  StallCycles <= StallCycles + 32'd1;
  end

  muldiv_busy_counter #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) uMulDiv (
    .clk  (clk),
    .rst  (rst),
    .start(MulDivStart_EX & ~freeze),
    .busy (MulDivBusy),
    .done (MulDivDone)
  );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges four hazard sources into one set of per-stage write-enable and flush controls:
- load-use
- multiply/divide unit busy
- data-memory wait states
- taken branch/jump

It owns the mul/div busy counter, a memory-wait watchdog and a stall-cycle performance counter. It sits beside the ID stage and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
MULDIV_CYCLES, 32, cycles the iterative mul/div unit is busy after a start (1..63)
MEM_TIMEOUT, 255, max consecutive data-memory wait cycles before error (1..1023)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
RegSource_ID  input  5  rs of instruction in ID
RegTarget_ID  input  5  rt of instruction in ID
UsesRs_ID  input  1  ID instruction reads rs
UsesRt_ID  input  1  ID instruction reads rt
HiLoAccess_ID  input  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
BranchTaken_ID  input  1  branch/jump resolved taken in ID
WriteRegAddr_EX  input  5  destination register of EX instruction
MemRead_EX  input  3  load type in EX, 000 = not a load
MulDivStart_EX  input  1  mult/div issuing in EX this cycle
MemAccess_MEM  input  1  MEM stage performing load/store
DMemReady  input  1  data memory acknowledges access this cycle
PCWrite  output  1  PC update enable
IFID_Write  output  1  IF/ID register enable
IFID_Flush  output  1  IF/ID clear to nop
IDEX_Flush  output  1  insert bubble into ID/EX
EXMEM_Write  output  1  EX/MEM register enable
MEMWB_Flush  output  1  insert bubble into MEM/WB
MulDivBusy  output  1  mul/div unit busy
MulDivDone  output  1  one-cycle pulse, result valid in HI/LO
MemTimeout  output  1  sticky error, memory wait exceeded MEM_TIMEOUT
StallCycles  output  32  saturating count of cycles with PCWrite=0

Behaviour:
- Hazard terms, all combinational:
  - freeze = MemAccess_MEM & ~DMemReady
  - md_haz = HiLoAccess_ID & MulDivBusy
  - lu_haz = (MemRead_EX != 0) & (WriteRegAddr_EX != 0) & ((UsesRs_ID & WriteRegAddr_EX == RegSource_ID) | (UsesRt_ID & WriteRegAddr_EX == RegTarget_ID))
- Register $0 and unused operands never cause a stall.
- Priority 1, freeze: PCWrite=0, IFID_Write=0, EXMEM_Write=0, MEMWB_Flush=1, IDEX_Flush=0. ID/EX holds its contents. MulDivStart_EX is ignored.
- Priority 2, md_haz or lu_haz: PCWrite=0, IFID_Write=0, IDEX_Flush=1, EXMEM_Write=1.
- Priority 3, BranchTaken_ID: IFID_Flush=1. All enables remain 1.
- BranchTaken_ID is ignored whenever priority 1 or 2 is active, because the branch operands are not yet valid.
- Default outputs: PCWrite=IFID_Write=EXMEM_Write=1, all flushes 0.
- Outputs are combinational, so they respond in the same cycle.
- State FSM, 2 states, registered:
  - RUN -> MEM_WAIT when freeze.
  - MEM_WAIT -> RUN when DMemReady or ~MemAccess_MEM.
  - In MEM_WAIT a 10-bit wait counter increments each cycle.
  - When the wait counter reaches MEM_TIMEOUT, MemTimeout sets. It stays set until rst.
  - The wait counter clears on entry to RUN.
- Mul/div counter, 6-bit:
  - Loads MULDIV_CYCLES on the edge where MulDivStart_EX & ~freeze.
  - Otherwise decrements while nonzero.
  - MulDivBusy = (counter != 0).
  - MulDivDone pulses for the cycle after the counter transitions 1 -> 0.
  - A start while already busy reloads the counter. Upstream md_haz prevents this case; the bench checks it never occurs.
  - The counter keeps decrementing during freeze.
- StallCycles: increments on every edge where PCWrite=0. It saturates at 0xFFFFFFFF.
- Reset, asynchronous:
  - Takes effect immediately, mid-operation included.
  - Clears: state=RUN, wait counter, mul/div counter, MemTimeout, StallCycles, MulDivDone.
  - With hazard inputs inactive, outputs are the defaults and MulDivBusy=0.

Decomposition:
- Shared package holds:
  - FSM state encodings ST_RUN, ST_MEM_WAIT
  - MEMREAD_NONE = 3'b000
  - REG_ZERO = 5'd0
- One natural sub-module: muldiv_busy_counter, containing the counter, busy flag and done pulse.

Test Plan:
- Load-use: MemRead_EX=3'b001, WriteRegAddr_EX=8, RegSource_ID=8, UsesRs_ID=1 -> PCWrite=0, IFID_Write=0, IDEX_Flush=1. Repeat with WriteRegAddr_EX=0 or UsesRs_ID=0 -> no stall.
- Mul/div: MulDivStart_EX for 1 cycle with MULDIV_CYCLES=4 -> MulDivBusy high for 4 cycles, MulDivDone pulses on the 5th. HiLoAccess_ID=1 during busy -> PCWrite=0 and IDEX_Flush=1 until busy drops.
- Memory wait: MemAccess_MEM=1, DMemReady=0 for 3 cycles -> EXMEM_Write=0, MEMWB_Flush=1, IDEX_Flush=0, StallCycles += 3. Raise DMemReady -> FSM returns to RUN.
- Simultaneous events: freeze, lu_haz and BranchTaken_ID in the same cycle -> freeze outputs only, IFID_Flush=0. Remove the freeze -> load-use stall. Remove the load -> IFID_Flush=1 for exactly 1 cycle.
- Timeout: MEM_TIMEOUT=5, DMemReady held low -> MemTimeout rises after 5 wait cycles and stays high after DMemReady=1. Assert rst mid-wait -> MemTimeout, StallCycles and MulDivBusy are immediately 0.
